// File: rtl/dc_pwm.sv
// Edge-aligned 13-bit PWM for a half-bridge with complementary gate drives,
// glitch-free duty updates at period boundaries and run-length dead-time.
module dc_pwm #(
    parameter int unsigned DEADTIME = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] duty,
    input  logic        duty_vld,
    input  logic        en,
    output logic        pwm_hi,
    output logic        pwm_lo,
    output logic        cycle_start
);

    localparam int unsigned CW = 13;
    localparam int unsigned RW = 9;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [RW-1:0] RL_SAT  = RW'(DEADTIME + 1);
    localparam logic [RW-1:0] RL_THR  = RW'(DEADTIME);

    logic [CW-1:0] cnt;
    logic [CW-1:0] shadow;
    logic [CW-1:0] active;
    logic [RW-1:0] rl;
    logic          raw_q;
    logic          en_q;

    logic [CW-1:0] duty_clamp_c;
    logic          period_end_c;
    logic          raw_c;
    logic          same_c;
    logic [RW-1:0] rl_next_c;
    logic          settled_c;

    // Negative commands saturate to zero duty; non-negative pass through.
    always_comb begin
        duty_clamp_c = duty[13] ? '0 : duty[12:0];
    end

    // Raw comparator output plus run-length tracking of the current raw level.
    // A run restarts whenever raw toggles or the stage was disabled last cycle,
    // so rl_next_c is (consecutive equal cycles ending now) - 1, saturated.
    always_comb begin
        period_end_c = (cnt == CNT_MAX);
        raw_c        = en && (cnt < active);
        same_c       = en && en_q && (raw_c == raw_q);
        rl_next_c    = '0;
        if (same_c) begin
            rl_next_c = (rl == RL_SAT) ? rl : rl + RW'(1);
        end
        settled_c    = (rl_next_c >= RL_THR);
    end

    // Period counter: free-running while enabled, parked at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Shadow holds the last strobed command until the next period boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (duty_vld) begin
            shadow <= duty_clamp_c;
        end
    end

    // Active duty only changes at a boundary (or freely while disabled);
    // a strobe coinciding with the boundary bypasses the shadow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= '0;
        end else if (!en || period_end_c) begin
            active <= duty_vld ? duty_clamp_c : shadow;
        end
    end

    // Run-length state and history of raw/en for dead-time insertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rl    <= '0;
            raw_q <= 1'b0;
            en_q  <= 1'b0;
        end else begin
            rl    <= rl_next_c;
            raw_q <= raw_c;
            en_q  <= en;
        end
    end

    // Gate drives follow raw only after it has been stable DEADTIME+1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_hi      <= 1'b0;
            pwm_lo      <= 1'b0;
            cycle_start <= 1'b0;
        end else begin
            pwm_hi      <= raw_c && settled_c;
            pwm_lo      <= en && !raw_c && settled_c;
            cycle_start <= en && (cnt == '0);
        end
    end

endmodule
